// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target.
package i2c_pkg;

    localparam int unsigned I2C_ADDR_W = 7;
    localparam int unsigned I2C_BYTE_W = 8;

    // Default address of the SHT40 humidity/temperature sensor
    localparam logic [I2C_ADDR_W-1:0] SHT40_ADDR = 7'h44;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_IGNORE,
        ST_ADDR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_RD_STRETCH
    } tgt_state_t;

    // Address byte is {addr[6:0], r/w}
    function automatic logic addr_match(input logic [I2C_BYTE_W-1:0] addr_byte,
                                        input logic [I2C_ADDR_W-1:0] addr);
        return addr_byte[I2C_BYTE_W-1:1] == addr;
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizer with SCL edge and START/STOP condition detection.
// Flops reset to 1 (idle bus level) so reset release does not fake an edge.
// SYNC_STAGES must be at least 2.
module i2c_bus_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_hist;
    logic                   sda_hist;
    logic                   scl;

    // Synchronizer chains plus one history flop per line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_hist <= 1'b1;
            sda_hist <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_hist <= scl_sync[SYNC_STAGES-1];
            sda_hist <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl       = scl_sync[SYNC_STAGES-1];
    assign sda       = sda_sync[SYNC_STAGES-1];
    assign scl_rise  =  scl & ~scl_hist;
    assign scl_fall  = ~scl &  scl_hist;
    assign start_det =  scl & scl_hist &  sda_hist & ~sda;
    assign stop_det  =  scl & scl_hist & ~sda_hist &  sda;

endmodule

// File: rtl/i2c_target.sv
// I2C target: address match/ACK, write bytes to fabric, read bytes from fabric.
// Optional clock stretching on read underrun: define I2C_TARGET_CLK_STRETCH_EN.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = SHT40_ADDR,
    parameter int unsigned           SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_oe,
    output logic                  scl_oe,
    output logic [I2C_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_req,
    input  logic [I2C_BYTE_W-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_underrun,
    output logic                  busy
);

    tgt_state_t            state;
    logic [I2C_BYTE_W-1:0] shift;
    logic [3:0]            bit_cnt;
    logic                  sda;
    logic                  scl_rise;
    logic                  scl_fall;
    logic                  start_det;
    logic                  stop_det;
    logic                  load_now;

    i2c_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    // Byte-load points: end of address ACK on a read, end of master ACK
    assign load_now = scl_fall && !start_det && !stop_det &&
                      ((state == ST_ADDR_ACK && shift[0]) || state == ST_RD_ACK);

`ifdef I2C_TARGET_CLK_STRETCH_EN
    logic [1:0] stretch_cnt;
`else
    logic [I2C_BYTE_W-1:0] load_byte;
    assign load_byte = tx_valid ? tx_data : 8'hFF;
    assign scl_oe    = 1'b0;
`endif

    // Protocol FSM; START/STOP override data edges, byte loads override the case
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            shift       <= '0;
            bit_cnt     <= '0;
            sda_oe      <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_req      <= 1'b0;
            tx_underrun <= 1'b0;
            busy        <= 1'b0;
`ifdef I2C_TARGET_CLK_STRETCH_EN
            scl_oe      <= 1'b0;
            stretch_cnt <= '0;
`endif
        end else begin
            rx_valid    <= 1'b0;
            tx_req      <= 1'b0;
            tx_underrun <= 1'b0;
            if (start_det) begin
                state   <= ST_ADDR;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
`ifdef I2C_TARGET_CLK_STRETCH_EN
                scl_oe  <= 1'b0;
`endif
            end else if (stop_det) begin
                state  <= ST_IDLE;
                busy   <= 1'b0;
                sda_oe <= 1'b0;
`ifdef I2C_TARGET_CLK_STRETCH_EN
                scl_oe <= 1'b0;
`endif
            end else begin
                case (state)
                    ST_ADDR: begin
                        if (scl_rise && bit_cnt < 4'd8) begin
                            shift   <= {shift[6:0], sda};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            if (addr_match(shift, TARGET_ADDR)) begin
                                state  <= ST_ADDR_ACK;
                                sda_oe <= 1'b1;
                                busy   <= 1'b1;
                            end else begin
                                state  <= ST_IGNORE;
                                busy   <= 1'b0;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall && !shift[0]) begin
                            state   <= ST_WR_DATA;
                            sda_oe  <= 1'b0;
                            bit_cnt <= '0;
                        end
                    end
                    ST_WR_DATA: begin
                        if (scl_rise && bit_cnt < 4'd8) begin
                            shift   <= {shift[6:0], sda};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
                            sda_oe   <= 1'b1;
                            state    <= ST_WR_ACK;
                        end
                    end
                    ST_WR_ACK: begin
                        if (scl_fall) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= '0;
                            state   <= ST_WR_DATA;
                        end
                    end
                    ST_RD_DATA: begin
                        if (scl_fall) begin
                            if (bit_cnt == 4'd7) begin
                                sda_oe <= 1'b0;
                                tx_req <= 1'b1;
                                state  <= ST_RD_ACK;
                            end else begin
                                shift   <= {shift[6:0], 1'b0};
                                sda_oe  <= ~shift[6];
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        if (scl_rise && sda) begin
                            state <= ST_IGNORE;
                        end
                    end
`ifdef I2C_TARGET_CLK_STRETCH_EN
                    ST_RD_STRETCH: begin
                        if (stretch_cnt == 2'd0) begin
                            if (tx_valid) begin
                                shift       <= tx_data;
                                sda_oe      <= ~tx_data[7];
                                stretch_cnt <= 2'd1;
                            end
                        end else if (stretch_cnt == 2'd1) begin
                            stretch_cnt <= 2'd2;
                        end else begin
                            scl_oe      <= 1'b0;
                            stretch_cnt <= '0;
                            bit_cnt     <= '0;
                            state       <= ST_RD_DATA;
                        end
                    end
`endif
                    default: ;
                endcase
                if (load_now) begin
`ifdef I2C_TARGET_CLK_STRETCH_EN
                    if (tx_valid) begin
                        shift   <= tx_data;
                        sda_oe  <= ~tx_data[7];
                        bit_cnt <= '0;
                        state   <= ST_RD_DATA;
                    end else begin
                        scl_oe      <= 1'b1;
                        sda_oe      <= 1'b0;
                        stretch_cnt <= '0;
                        state       <= ST_RD_STRETCH;
                    end
`else
                    shift       <= load_byte;
                    sda_oe      <= ~load_byte[7];
                    bit_cnt     <= '0;
                    tx_underrun <= ~tx_valid;
                    state       <= ST_RD_DATA;
`endif
                end
            end
        end
    end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (responder) that sits on the same SCL/SDA bus the master-side SCL generator drives.
- Used as an on-chip SHT40 stand-in for system bring-up, and as a bus peripheral endpoint.
- Detects START and STOP, matches a 7-bit address and ACKs it.
- Write transfers: delivers received bytes to the fabric. Read transfers: shifts out fabric-supplied bytes. SDA (and optionally SCL) are driven open-drain.

Parameters:
- TARGET_ADDR, 7'h44, 7-bit address this target answers to (SHT40 default).
- SYNC_STAGES, 2, flip-flop stages on scl_in/sda_in; minimum 2.

Ports:
- clk  input  1  system clock; must be at least 16x the SCL frequency.
- rst_n  input  1  asynchronous active-low reset.
- scl_in  input  1  bus SCL level, asynchronous.
- sda_in  input  1  bus SDA level, asynchronous.
- sda_oe  output  1  1 = pull SDA low; 0 = release.
- scl_oe  output  1  1 = pull SCL low (stretch); constant 0 without the optional feature.
- rx_data  output  8  last byte received in a write transfer.
- rx_valid  output  1  one-cycle pulse; rx_data is valid.
- tx_req  output  1  one-cycle pulse requesting the next read byte.
- tx_data  input  8  read byte supplied by the fabric.
- tx_valid  input  1  tx_data is valid; sampled at load time.
- tx_underrun  output  1  one-cycle pulse; byte loaded while tx_valid was low.
- busy  output  1  high from an address match until STOP or a non-matching repeated START.

Behaviour:
- Reset values: all outputs 0, state IDLE, shift register 0, bit counter 0.
- Input conditioning: scl_in/sda_in pass through SYNC_STAGES flops, plus one history flop for edge detection.
- Edges:
  - scl_rise / scl_fall come from the synchronized SCL.
  - START = synchronized SDA falls while SCL high. STOP = SDA rises while SCL high.
- START/STOP apply from any state and take priority over data edges in the same cycle.
  - START → ADDR, bit counter cleared, sda_oe released.
  - STOP → IDLE, busy 0, sda_oe released.
- Data timing: SDA sampled on scl_rise; sda_oe changes only on scl_fall. Latency from a bus edge to an sda_oe change is SYNC_STAGES+1 clk.
- States:
  - IDLE: ignore everything except START.
  - ADDR: shift 8 bits MSB first. On the 8th scl_fall:
    - address matches → ADDR_ACK, sda_oe=1, busy=1;
    - mismatch → IGNORE.
  - IGNORE: released, waits for START/STOP.
  - ADDR_ACK: on the next scl_fall, branch on R/W.
    - R/W=0 → WR_DATA, release SDA.
    - R/W=1 → load byte, drive bit7, enter RD_DATA.
  - WR_DATA: shift 8 bits. On the 8th scl_fall: rx_data updated, rx_valid pulse, sda_oe=1 → WR_ACK. Every byte is ACKed.
  - WR_ACK: on scl_fall, release SDA → WR_DATA, bit counter cleared.
  - RD_DATA: sda_oe = ~shift[7]; shift on each scl_fall. After the 8th bit's scl_fall: release SDA, tx_req pulse → RD_ACK.
  - RD_ACK: sample the master ACK on scl_rise.
    - ACK (0): on scl_fall, load the next byte and drive bit7 → RD_DATA.
    - NACK (1): → IGNORE, busy stays 1 until STOP.
- Byte load: tx_data when tx_valid=1. Otherwise 8'hFF plus a tx_underrun pulse.
- Repeated START mid-byte: partial byte discarded, no rx_valid.
- Reset mid-transfer: SDA/SCL released immediately (async).

Optional Feature:
- I2C_TARGET_CLK_STRETCH_EN
  - Defined: at a byte-load point with tx_valid=0, set scl_oe=1 and hold until tx_valid=1, then load tx_data, wait 2 clk, release scl_oe. No underrun pulse in this case.
  - START/STOP/reset release scl_oe.
  - Undefined: scl_oe tied 0; the underrun path is used.

Decomposition:
- Package i2c_pkg:
  - target state enum;
  - I2C_ADDR_W=7, I2C_BYTE_W=8;
  - default SHT40 address constant.
- Sub-module i2c_bus_sync: synchronizer plus edge/START/STOP detection, parameterised by SYNC_STAGES.

Test Plan:
- Write 0x44+W, bytes 0x24, 0x00, STOP → three ACKs on the bus; rx_valid twice with 0x24 then 0x00; busy falls after STOP.
- Address 0x45+W → no ACK (SDA high on 9th clock); no rx_valid; busy stays 0.
- Read 0x44+R, tx_valid=1 with 0xBE then 0xEF; master ACK then NACK → bus carries 0xBE, 0xEF; two tx_req pulses; target releases after NACK.
- Read with tx_valid=0:
  - without the macro → 0xFF on the bus plus tx_underrun;
  - with the macro → SCL held low until tx_valid is raised 50 clk later, then correct byte.
- Repeated START after 4 bits of a write byte, then 0x44+R → partial byte dropped, read proceeds normally.
- rst_n asserted while the target drives the ACK → sda_oe 0 within the same cycle (async); IDLE after release.
